// File: rtl/sequential_shifter_if.sv
// Operand/result handshake bundle for the sequential shifter.
// The master side issues operands and consumes results; the slave side is the shifter.
interface sequential_shifter_if #(
  parameter int N       = 32,
  parameter int SHAMT_W = $clog2(N)
);
  logic               i_valid;
  logic               i_ready;
  logic [1:0]         op;
  logic [N-1:0]       in;
  logic [SHAMT_W-1:0] shamt;
  logic               o_valid;
  logic               o_ready;
  logic [N-1:0]       out;
  logic               busy;

  modport master (
    output i_valid, op, in, shamt, o_ready,
    input  i_ready, o_valid, out, busy
  );

  modport slave (
    input  i_valid, op, in, shamt, o_ready,
    output i_ready, o_valid, out, busy
  );
endinterface

// File: rtl/sequential_shifter.sv
// Multi-cycle SLL/SRL/SRA/ROL unit: one 1-bit step per clock, shamt steps per operation.
// Latency shamt+1 cycles from accept to o_valid; holds the result until o_ready, accepts only when idle.
module sequential_shifter #(
  parameter int N       = 32,
  parameter int SHAMT_W = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  sequential_shifter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q;
  logic [N-1:0]       data_q;
  logic [N-1:0]       data_d;
  logic [N-1:0]       out_q;
  logic [1:0]         op_q;
  logic [SHAMT_W-1:0] count_q;
  logic               o_valid_q;

  // Single-bit step of the latched operation.
  always_comb begin
    data_d = data_q;
    case (op_q)
      2'b00:   data_d = {data_q[N-2:0], 1'b0};
      2'b01:   data_d = {1'b0, data_q[N-1:1]};
      2'b10:   data_d = {data_q[N-1], data_q[N-1:1]};
      default: data_d = {data_q[N-2:0], data_q[N-1]};
    endcase
  end

  assign bus.i_ready = (state_q == IDLE);
  assign bus.busy    = (state_q != IDLE);
  assign bus.o_valid = o_valid_q;
  assign bus.out     = out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      data_q    <= '0;
      out_q     <= '0;
      op_q      <= 2'b00;
      count_q   <= '0;
      o_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_valid) begin
            data_q  <= bus.in;
            op_q    <= bus.op;
            count_q <= bus.shamt;
            if (bus.shamt == '0) begin
              state_q   <= DONE;
              out_q     <= bus.in;
              o_valid_q <= 1'b1;
            end else begin
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          data_q  <= data_d;
          count_q <= count_q - 1'b1;
          // out only moves on entry to DONE so partial results never leak.
          if (count_q == SHAMT_W'(1)) begin
            state_q   <= DONE;
            out_q     <= data_d;
            o_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.o_ready) begin
            state_q   <= IDLE;
            o_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          o_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequential_shifter.sv
// Scoreboard bench for sequential_shifter: directed cases, backpressure, mid-op reset, random traffic.
module tb_sequential_shifter;
  localparam int N  = 32;
  localparam int SW = 5;

  typedef struct {
    logic [N-1:0] dat;
    int           due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sequential_shifter_if #(.N(N), .SHAMT_W(SW)) bus();

  sequential_shifter #(.N(N), .SHAMT_W(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc    = 0;
  int           hs_cyc = 0;
  int           acc_cyc = 0;
  logic         ov_prev  = 1'b0;
  logic         or_prev  = 1'b0;
  logic         rst_prev = 1'b0;
  logic [N-1:0] out_prev = '0;
  logic         rand_mode  = 1'b0;
  logic         ordy_fixed = 1'b1;
  logic         ordy_rand  = 1'b1;

  assign bus.o_ready = rand_mode ? ordy_rand : ordy_fixed;

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #1 ordy_rand = 1'($urandom_range(0, 1));
  end

  // Reference: whole shift in one arithmetic step.
  function automatic logic [N-1:0] ref_shift(input logic [1:0] op, input logic [N-1:0] v,
                                             input int sh);
    logic [N-1:0] r;
    case (op)
      2'b00:   r = v << sh;
      2'b01:   r = v >> sh;
      2'b10:   r = N'($signed(v) >>> sh);
      default: r = (sh == 0) ? v : ((v << sh) | (v >> (N - sh)));
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (rst_prev) begin
      chk("reset_out", bus.out, 0);
      chk("reset_o_valid", bus.o_valid, 0);
      chk("reset_i_ready", bus.i_ready, 1);
      chk("reset_busy", bus.busy, 0);
    end else begin
      chk("busy_vs_i_ready", bus.busy, !bus.i_ready);
      if (ov_prev && !or_prev) begin
        chk("hold_o_valid", bus.o_valid, 1);
        chk("hold_out", bus.out, out_prev);
      end
      if (bus.o_valid && !ov_prev) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got out=%h with empty scoreboard", bus.out);
        end else begin
          chk("latency", cyc, sb[0].due);
        end
      end else begin
        chk("out_stable", bus.out, out_prev);
      end
      if (bus.o_valid) begin
        chk("i_ready_in_done", bus.i_ready, 0);
        if (sb.size() > 0) chk("result", bus.out, sb[0].dat);
        if (bus.o_ready) begin
          hs_cyc = cyc;
          if (sb.size() > 0) void'(sb.pop_front());
        end
      end
    end
    if (rst) begin
      sb.delete();
    end else if (bus.i_valid && bus.i_ready) begin
      sb.push_back('{dat: ref_shift(bus.op, bus.in, int'(bus.shamt)),
                     due: cyc + 1 + int'(bus.shamt)});
      acc_cyc = cyc;
    end
    ov_prev  = bus.o_valid;
    or_prev  = bus.o_ready;
    out_prev = bus.out;
    rst_prev = rst;
  end

  task automatic send(input logic [1:0] op, input logic [N-1:0] v, input logic [SW-1:0] sh);
    logic acc;
    acc         = 1'b0;
    bus.op      = op;
    bus.in      = v;
    bus.shamt   = sh;
    bus.i_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      acc = bus.i_ready && !rst;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept within 300 cycles");
    end
    bus.i_valid = 1'b0;
    bus.in      = N'($urandom);
    bus.op      = 2'($urandom);
    bus.shamt   = SW'($urandom);
  endtask

  task automatic drain();
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0 && bus.i_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.i_valid = 1'b0;
    bus.op      = 2'b00;
    bus.in      = '0;
    bus.shamt   = '0;
    rst         = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases.
    send(2'b00, 32'h0000_0001, 5'd31); drain();
    send(2'b10, 32'h8000_0000, 5'd4);  drain();
    send(2'b01, 32'h8000_0000, 5'd4);  drain();
    send(2'b00, 32'hDEAD_BEEF, 5'd0);  drain();
    send(2'b11, 32'h8000_0001, 5'd1);  drain();
    send(2'b11, 32'h1234_5678, 5'd8);  drain();

    // Backpressure with a second operand waiting.
    ordy_fixed = 1'b0;
    send(2'b10, 32'hA5A5_0F0F, 5'd3);
    fork
      send(2'b01, 32'h0000_FF00, 5'd4);
      begin
        for (int k = 0; k < 50; k++) begin
          @(negedge clk);
          if (bus.o_valid) break;
        end
        repeat (5) @(posedge clk);
        #1 ordy_fixed = 1'b1;
      end
    join
    chk("accept_after_handshake", acc_cyc, hs_cyc + 1);
    drain();

    // Reset in the middle of a shift.
    send(2'b00, 32'hFFFF_FFFF, 5'd20);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    send(2'b01, 32'hF000_0000, 5'd28); drain();

    // Random traffic with random result backpressure.
    rand_mode = 1'b1;
    for (int i = 0; i < 150; i++) begin
      send(2'($urandom), N'($urandom), SW'($urandom_range(0, N - 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rand_mode  = 1'b0;
    ordy_fixed = 1'b1;
    drain();

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
